// File: rtl/eth_frame_fifo_stats.sv
// Store-and-forward Ethernet frame FIFO with per-frame good/bad/overflow/
// oversize classification, one-cycle status pulses and saturating counters.
//
// Ports:
//   clk, rst_n             : single clock, asynchronous active-low reset
//   s_axis_*               : AXI-Stream input (tuser=1 on tlast marks bad frame)
//   m_axis_*               : AXI-Stream output (tuser always 0)
//   stat_clear             : synchronous clear of all counters
//   status_*               : one-cycle pulse per classified frame
//   cnt_*                  : saturating per-class frame counters
module eth_frame_fifo_stats #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 4096,
    parameter int MAX_FRAME_BEATS = 1522,
    parameter int COUNT_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    input  logic                   stat_clear,
    output logic                   status_good_frame,
    output logic                   status_bad_frame,
    output logic                   status_overflow,
    output logic                   status_oversize,
    output logic [COUNT_WIDTH-1:0] cnt_good,
    output logic [COUNT_WIDTH-1:0] cnt_bad,
    output logic [COUNT_WIDTH-1:0] cnt_overflow,
    output logic [COUNT_WIDTH-1:0] cnt_oversize
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(MAX_FRAME_BEATS + 2);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [BW-1:0] MAX_B   = BW'(MAX_FRAME_BEATS);
    localparam int CW = COUNT_WIDTH;

    logic [DATA_WIDTH:0] mem_q [DEPTH];

    logic [PW-1:0] wr_cmt_q, wr_cmt_d;
    logic [PW-1:0] wr_cur_q, wr_cur_d;
    logic [PW-1:0] rd_q, rd_d;
    logic          drop_q, drop_d;
    logic          rsn_ovf_q, rsn_ovf_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          tready_q;

    logic [DATA_WIDTH-1:0] odata_q, odata_d;
    logic                  olast_q, olast_d;
    logic                  ovalid_q, ovalid_d;

    logic st_good_q, st_bad_q, st_ovf_q, st_osz_q;
    logic [CW-1:0] c_good_q, c_bad_q, c_ovf_q, c_osz_q;

    logic beat_ok, full, ovf_hit, osz_hit, drop_now, rsn_ovf;
    logic wr_en, eop, ev_good, ev_bad, ev_ovf, ev_osz, load;

    always_comb begin
        beat_ok  = s_axis_tvalid && tready_q;
        full     = (wr_cur_q - rd_q) == DEPTH_P;
        ovf_hit  = beat_ok && !drop_q && full;
        osz_hit  = beat_ok && !drop_q && (beat_q == MAX_B);
        drop_now = drop_q || ovf_hit || osz_hit;
        // overflow wins when both fire on the same beat
        rsn_ovf  = drop_q ? rsn_ovf_q : ovf_hit;
        wr_en    = beat_ok && !drop_now;
        eop      = beat_ok && s_axis_tlast;
        ev_good  = eop && !drop_now && !s_axis_tuser;
        ev_bad   = eop && !drop_now && s_axis_tuser;
        ev_ovf   = eop && drop_now && rsn_ovf;
        ev_osz   = eop && drop_now && !rsn_ovf;
    end

    always_comb begin
        wr_cur_d  = wr_cur_q;
        wr_cmt_d  = wr_cmt_q;
        drop_d    = drop_q;
        rsn_ovf_d = rsn_ovf_q;
        beat_d    = beat_q;
        if (ovf_hit || osz_hit) begin
            wr_cur_d  = wr_cmt_q;
            rsn_ovf_d = ovf_hit;
        end else if (wr_en) begin
            if (eop && s_axis_tuser) begin
                wr_cur_d = wr_cmt_q;
            end else begin
                wr_cur_d = wr_cur_q + 1'b1;
            end
        end
        if (ev_good) begin
            wr_cmt_d = wr_cur_q + 1'b1;
        end
        if (beat_ok) begin
            drop_d = drop_now;
            if (wr_en) begin
                beat_d = beat_q + 1'b1;
            end
        end
        if (eop) begin
            drop_d = 1'b0;
            beat_d = '0;
        end
    end

    always_comb begin
        load     = (!ovalid_q || m_axis_tready) && (rd_q != wr_cmt_q);
        rd_d     = rd_q;
        odata_d  = odata_q;
        olast_d  = olast_q;
        ovalid_d = ovalid_q;
        if (load) begin
            ovalid_d = 1'b1;
            odata_d  = mem_q[rd_q[AW-1:0]][DATA_WIDTH-1:0];
            olast_d  = mem_q[rd_q[AW-1:0]][DATA_WIDTH];
            rd_d     = rd_q + 1'b1;
        end else if (m_axis_tready) begin
            ovalid_d = 1'b0;
        end
    end

    // clear beats saturation; a simultaneous event leaves the count at 1
    function automatic logic [CW-1:0] cnt_nxt(
        input logic [CW-1:0] c,
        input logic          ev,
        input logic          clr
    );
        if (clr) begin
            return CW'(ev);
        end else if (ev && (c != '1)) begin
            return c + 1'b1;
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_cur_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cmt_q  <= '0;
            wr_cur_q  <= '0;
            rd_q      <= '0;
            drop_q    <= 1'b0;
            rsn_ovf_q <= 1'b0;
            beat_q    <= '0;
            tready_q  <= 1'b0;
            odata_q   <= '0;
            olast_q   <= 1'b0;
            ovalid_q  <= 1'b0;
            st_good_q <= 1'b0;
            st_bad_q  <= 1'b0;
            st_ovf_q  <= 1'b0;
            st_osz_q  <= 1'b0;
            c_good_q  <= '0;
            c_bad_q   <= '0;
            c_ovf_q   <= '0;
            c_osz_q   <= '0;
        end else begin
            wr_cmt_q  <= wr_cmt_d;
            wr_cur_q  <= wr_cur_d;
            rd_q      <= rd_d;
            drop_q    <= drop_d;
            rsn_ovf_q <= rsn_ovf_d;
            beat_q    <= beat_d;
            tready_q  <= 1'b1;
            odata_q   <= odata_d;
            olast_q   <= olast_d;
            ovalid_q  <= ovalid_d;
            st_good_q <= ev_good;
            st_bad_q  <= ev_bad;
            st_ovf_q  <= ev_ovf;
            st_osz_q  <= ev_osz;
            c_good_q  <= cnt_nxt(c_good_q, ev_good, stat_clear);
            c_bad_q   <= cnt_nxt(c_bad_q, ev_bad, stat_clear);
            c_ovf_q   <= cnt_nxt(c_ovf_q, ev_ovf, stat_clear);
            c_osz_q   <= cnt_nxt(c_osz_q, ev_osz, stat_clear);
        end
    end

    assign s_axis_tready     = tready_q;
    assign m_axis_tdata      = odata_q;
    assign m_axis_tvalid     = ovalid_q;
    assign m_axis_tlast      = olast_q;
    assign m_axis_tuser      = 1'b0;
    assign status_good_frame = st_good_q;
    assign status_bad_frame  = st_bad_q;
    assign status_overflow   = st_ovf_q;
    assign status_oversize   = st_osz_q;
    assign cnt_good          = c_good_q;
    assign cnt_bad           = c_bad_q;
    assign cnt_overflow      = c_ovf_q;
    assign cnt_oversize      = c_osz_q;

endmodule

// File: tb/tb_eth_frame_fifo_stats.sv
// Directed bench: instance a (DEPTH 16, MAX 32, 32-bit counters) and
// instance b (DEPTH 16, MAX 8, 2-bit counters) share one stimulus stream.
module tb_eth_frame_fifo_stats;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tlast = 1'b0;
    logic       s_tuser = 1'b0;
    logic       m_tready = 1'b0;
    logic       stat_clear = 1'b0;

    logic        a_sready, a_mvalid, a_mlast, a_muser;
    logic [7:0]  a_mdata;
    logic        a_sg, a_sb, a_so, a_sz;
    logic [31:0] a_cg, a_cb, a_co, a_cz;

    logic        b_sready, b_mvalid, b_mlast, b_muser;
    logic [7:0]  b_mdata;
    logic        b_sg, b_sb, b_so, b_sz;
    logic [1:0]  b_cg, b_cb, b_co, b_cz;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    eth_frame_fifo_stats #(
        .DATA_WIDTH(8), .DEPTH(16), .MAX_FRAME_BEATS(32), .COUNT_WIDTH(32)
    ) u_a (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(a_sready), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser),
        .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(a_mlast),
        .m_axis_tuser(a_muser), .stat_clear(stat_clear),
        .status_good_frame(a_sg), .status_bad_frame(a_sb),
        .status_overflow(a_so), .status_oversize(a_sz),
        .cnt_good(a_cg), .cnt_bad(a_cb),
        .cnt_overflow(a_co), .cnt_oversize(a_cz)
    );

    eth_frame_fifo_stats #(
        .DATA_WIDTH(8), .DEPTH(16), .MAX_FRAME_BEATS(8), .COUNT_WIDTH(2)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(b_sready), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser),
        .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(b_mlast),
        .m_axis_tuser(b_muser), .stat_clear(stat_clear),
        .status_good_frame(b_sg), .status_bad_frame(b_sb),
        .status_overflow(b_so), .status_oversize(b_sz),
        .cnt_good(b_cg), .cnt_bad(b_cb),
        .cnt_overflow(b_co), .cnt_oversize(b_cz)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // drives n beats starting at d0; returns at the negedge where the
    // status pulse for the frame is visible
    task automatic send(input int n, input logic [7:0] d0,
                        input logic usr, input logic clr_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = d0 + 8'(i);
            s_tlast  = (i == n - 1);
            s_tuser  = usr && (i == n - 1);
            stat_clear = clr_last && (i == n - 1);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        stat_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        m_tready = 1'b1;
        idle(2);
        check("rst_sready", a_sready, 0);
        check("rst_mvalid", a_mvalid, 0);
        check("rst_mdata", a_mdata, 0);
        check("rst_status", {a_sg, a_sb, a_so, a_sz}, 0);
        check("rst_cnt", a_cg | a_cb | a_co | a_cz, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("sready_up", a_sready, 1);

        // good 4-beat frame
        send(4, 8'h01, 1'b0, 1'b0);
        check("g_pulse", {a_sg, a_sb, a_so, a_sz}, 4'b1000);
        check("g_cnt", a_cg, 1);
        check("g_lat1", a_mvalid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("g_valid", a_mvalid, 1);
            check("g_data", a_mdata, 32'(i + 1));
            check("g_last", a_mlast, (i == 3));
            check("g_user", a_muser, 0);
        end
        @(negedge clk);
        check("g_end", a_mvalid, 0);

        // bad frame
        send(3, 8'h30, 1'b1, 1'b0);
        check("b_pulse", {a_sg, a_sb, a_so, a_sz}, 4'b0100);
        check("b_cnt", a_cb, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b_empty", a_mvalid, 0);
        end

        // overflow then intact frame, output stalled
        m_tready = 1'b0;
        send(20, 8'h40, 1'b0, 1'b0);
        check("o_pulse", {a_sg, a_sb, a_so, a_sz}, 4'b0010);
        check("o_cnt", a_co, 1);
        check("o_empty", a_mvalid, 0);
        send(4, 8'hA1, 1'b0, 1'b0);
        check("o2_pulse", a_sg, 1);
        check("o2_cnt", a_cg, 2);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("o2_hold_v", a_mvalid, 1);
            check("o2_hold_d", a_mdata, 32'hA1);
            check("o2_hold_l", a_mlast, 0);
        end
        m_tready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("o2_data", a_mdata, 32'hA1 + 32'(i));
            check("o2_last", a_mlast, (i == 3));
        end
        @(negedge clk);
        check("o2_end", a_mvalid, 0);

        // instance b: oversize and max-size frames
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(9, 8'h50, 1'b0, 1'b0);
        check("z_pulse", {b_sg, b_sb, b_so, b_sz}, 4'b0001);
        check("z_cnt", b_cz, 1);
        check("z_good", b_cg, 0);
        send(8, 8'h60, 1'b0, 1'b0);
        check("m_pulse", {b_sg, b_sb, b_so, b_sz}, 4'b1000);
        check("m_cnt", b_cg, 1);
        idle(1);
        check("m_first", b_mdata, 32'h60);
        idle(7);
        check("m_lastd", b_mdata, 32'h67);
        check("m_lastl", b_mlast, 1);

        // saturation and clear
        for (int i = 0; i < 4; i++) send(1, 8'h70, 1'b0, 1'b0);
        check("s_sat", b_cg, 3);
        send(2, 8'h80, 1'b0, 1'b1);
        check("c_pulse", b_sg, 1);
        check("c_good", b_cg, 1);
        check("c_osz", b_cz, 0);
        @(negedge clk);
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
        check("c_idle", b_cg, 0);

        // reset during output
        idle(4);
        send(4, 8'h91, 1'b0, 1'b0);
        idle(2);
        check("r_beat2", a_mdata, 32'h92);
        rst_n = 1'b0;
        #1;
        check("r_mvalid", a_mvalid, 0);
        check("r_mdata", a_mdata, 0);
        check("r_sready", a_sready, 0);
        check("r_cnt", a_cg | a_cb | a_co | a_cz, 0);
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("r_empty", a_mvalid, 0);
        end
        check("r_cnt2", a_cg | a_cb | a_co | a_cz, 0);
        send(2, 8'hC1, 1'b0, 1'b0);
        idle(1);
        check("r_new", a_mdata, 32'hC1);
        check("r_newv", a_mvalid, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
